fpu_seq64: RTL and testbench

Sequential IEEE-754 double-precision floating-point unit. It is the responder for the FPU command interface used by the Si-570 frequency-math controller. It accepts one OP strobe with operands A/B, computes a conversion, multiply or divide with iterative datapaths, and returns RESULT with a one-cycle fpu_done pulse. One operation is in flight at a time; command issue is serialized by the requester.

---
 rtl/fpu_seq64.sv | 240 ++++++++++++++++++++++++
 tb/tb_fpu_seq64.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_seq64.sv
// fpu_seq64: sequential IEEE-754 double FPU (to-float, to-int, shift-add multiply, restoring divide).
// Optional: define FPU_DIVIDE_EN to build the divider; otherwise OP=4 completes as an illegal opcode.
module fpu_seq64 (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  OP,
  input  logic [63:0] A,
  input  logic [63:0] B,
  output logic [63:0] RESULT,
  output logic        fpu_done,
  output logic        busy
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_UNPACK   = 3'd1;
  localparam logic [2:0] S_MUL_ITER = 3'd2;
  localparam logic [2:0] S_NORM     = 3'd4;
  localparam logic [2:0] S_PACK     = 3'd5;
  localparam logic [2:0] OP_TO_FLOAT = 3'd1;
  localparam logic [2:0] OP_TO_INT   = 3'd2;
  localparam logic [2:0] OP_MUL      = 3'd3;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef FPU_DIVIDE_EN
  localparam logic [2:0] S_DIV_ITER = 3'd3;
  localparam logic [2:0] OP_DIV     = 3'd4;
  logic [54:0] rem_r;
`endif

  logic [2:0]         state_r, op_r;
  logic [63:0]        a_r, b_r, res_r;
  logic               sign_r, nan_r, zero_r, inf_r;
  logic signed [12:0] exp_r;
  logic [105:0]       acc_r;
  logic [52:0]        opa_r, opb_r;
  logic [5:0]         cnt_r;

  logic [10:0]        ea_s, eb_s;
  logic [52:0]        ma_s, mb_s;
  logic               a_zero_s, b_zero_s, any_nan_s;
  logic [5:0]         msb_s;
  logic [63:0]        shifted_s, tofloat_s, toint_s, sig_s, norm_s;
  logic signed [12:0] ue_s, e_s;
  logic [51:0]        mant_s;

  assign ea_s      = a_r[62:52];
  assign eb_s      = b_r[62:52];
  assign ma_s      = {1'b1, a_r[51:0]};
  assign mb_s      = {1'b1, b_r[51:0]};
  assign a_zero_s  = (ea_s == 11'd0);
  assign b_zero_s  = (eb_s == 11'd0);
  assign any_nan_s = (ea_s == 11'h7FF) || (eb_s == 11'h7FF);

  // Integer to double: leading-one position sets the exponent, lower bits truncated into the mantissa
  always_comb begin
    msb_s = 6'd0;
    for (int i = 0; i < 64; i++) begin
      msb_s = a_r[i] ? 6'(i) : msb_s;
    end
    shifted_s = a_r << (6'd63 - msb_s);
    if (a_r == 64'd0) begin
      tofloat_s = 64'd0;
    end else begin
      tofloat_s = {1'b0, 11'd1023 + {5'd0, msb_s}, shifted_s[62:11]};
    end
  end

  // Double to unsigned integer, truncated toward zero and saturated at all ones
  always_comb begin
    ue_s  = $signed({2'b00, ea_s}) - 13'sd1023;
    sig_s = {11'd0, ma_s};
    if (ea_s == 11'h7FF) begin
      toint_s = ONES;
    end else if (a_r[63]) begin
      toint_s = 64'd0;
    end else if (ue_s < 13'sd0) begin
      toint_s = 64'd0;
    end else if (ue_s > 13'sd63) begin
      toint_s = ONES;
    end else if (ue_s >= 13'sd52) begin
      toint_s = sig_s << (ue_s[5:0] - 6'd52);
    end else begin
      toint_s = sig_s >> (6'd52 - ue_s[5:0]);
    end
  end

  // Normalize the multiply product or divide quotient and resolve special and range cases
  always_comb begin
    if (op_r == OP_MUL) begin
      if (acc_r[105]) begin
        mant_s = acc_r[104:53];
        e_s    = exp_r + 13'sd1;
      end else begin
        mant_s = acc_r[103:52];
        e_s    = exp_r;
      end
    end else begin
      if (acc_r[53]) begin
        mant_s = acc_r[52:1];
        e_s    = exp_r;
      end else begin
        mant_s = acc_r[51:0];
        e_s    = exp_r - 13'sd1;
      end
    end
    if (nan_r) begin
      norm_s = QNAN;
    end else if (inf_r || (e_s >= 13'sd2047)) begin
      norm_s = {sign_r, 11'h7FF, 52'd0};
    end else if (zero_r || (e_s <= 13'sd0)) begin
      norm_s = {sign_r, 63'd0};
    end else begin
      norm_s = {sign_r, e_s[10:0], mant_s};
    end
  end

  // Control FSM, iterative datapaths and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= S_IDLE;
      op_r     <= 3'd0;
      a_r      <= 64'd0;
      b_r      <= 64'd0;
      res_r    <= 64'd0;
      sign_r   <= 1'b0;
      nan_r    <= 1'b0;
      zero_r   <= 1'b0;
      inf_r    <= 1'b0;
      exp_r    <= 13'sd0;
      acc_r    <= 106'd0;
      opa_r    <= 53'd0;
      opb_r    <= 53'd0;
      cnt_r    <= 6'd0;
`ifdef FPU_DIVIDE_EN
      rem_r    <= 55'd0;
`endif
      RESULT   <= 64'd0;
      fpu_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      fpu_done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (OP != 3'd0) begin
            op_r    <= OP;
            a_r     <= A;
            b_r     <= B;
            busy    <= 1'b1;
            state_r <= S_UNPACK;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_UNPACK: begin
          sign_r <= a_r[63] ^ b_r[63];
          acc_r  <= 106'd0;
          opa_r  <= ma_s;
          opb_r  <= mb_s;
`ifdef FPU_DIVIDE_EN
          rem_r  <= {2'b00, ma_s};
`endif
          case (op_r)
            OP_TO_FLOAT: begin
              res_r   <= tofloat_s;
              state_r <= S_PACK;
            end
            OP_TO_INT: begin
              res_r   <= toint_s;
              state_r <= S_PACK;
            end
            OP_MUL: begin
              nan_r   <= any_nan_s;
              zero_r  <= a_zero_s | b_zero_s;
              inf_r   <= 1'b0;
              exp_r   <= $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - 13'sd1023;
              cnt_r   <= 6'd52;
              state_r <= S_MUL_ITER;
            end
`ifdef FPU_DIVIDE_EN
            OP_DIV: begin
              nan_r   <= any_nan_s | (a_zero_s & b_zero_s);
              zero_r  <= a_zero_s & ~b_zero_s;
              inf_r   <= b_zero_s & ~a_zero_s;
              exp_r   <= $signed({2'b00, ea_s}) - $signed({2'b00, eb_s}) + 13'sd1023;
              cnt_r   <= 6'd53;
              state_r <= S_DIV_ITER;
            end
`endif
            default: begin
              res_r   <= 64'd0;
              state_r <= S_PACK;
            end
          endcase
        end
        S_MUL_ITER: begin
          // MSB-first shift-add: one multiplier bit per cycle
          acc_r <= {acc_r[104:0], 1'b0} + (opb_r[52] ? {53'd0, opa_r} : 106'd0);
          opb_r <= {opb_r[51:0], 1'b0};
          cnt_r <= cnt_r - 6'd1;
          state_r <= (cnt_r == 6'd0) ? S_NORM : S_MUL_ITER;
        end
`ifdef FPU_DIVIDE_EN
        S_DIV_ITER: begin
          if (rem_r >= {2'b00, opb_r}) begin
            rem_r <= (rem_r - {2'b00, opb_r}) << 1;
            acc_r <= {acc_r[104:0], 1'b1};
          end else begin
            rem_r <= rem_r << 1;
            acc_r <= {acc_r[104:0], 1'b0};
          end
          cnt_r <= cnt_r - 6'd1;
          state_r <= (cnt_r == 6'd0) ? S_NORM : S_DIV_ITER;
        end
`endif
        S_NORM: begin
          res_r   <= norm_s;
          state_r <= S_PACK;
        end
        S_PACK: begin
          // Completion edge counts as idle: a strobe here starts the next operation
          RESULT   <= res_r;
          fpu_done <= 1'b1;
          if (OP != 3'd0) begin
            op_r    <= OP;
            a_r     <= A;
            b_r     <= B;
            busy    <= 1'b1;
            state_r <= S_UNPACK;
          end else begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_seq64.sv
// tb_fpu_seq64: directed and randomized checks of fpu_seq64 against an arithmetic reference model.
// Honors FPU_DIVIDE_EN the same way as the design.
module tb_fpu_seq64;
  logic        clk;
  logic        reset;
  logic [2:0]  OP;
  logic [63:0] A, B;
  logic [63:0] RESULT;
  logic        fpu_done;
  logic        busy;

  int n_checks;
  int n_errors;

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  fpu_seq64 dut (
    .clk(clk), .reset(reset), .OP(OP), .A(A), .B(B),
    .RESULT(RESULT), .fpu_done(fpu_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_dbl(input logic s, input int e, input logic [51:0] m);
    if (e >= 2047) return {s, 11'h7FF, 52'd0};
    if (e <= 0) return {s, 63'd0};
    return {s, 11'(e), m};
  endfunction

  function automatic logic [63:0] ref_to_float(input logic [63:0] a);
    int p;
    logic [127:0] frac;
    if (a == 64'd0) return 64'd0;
    p = 63;
    while (a[p] == 1'b0) p--;
    frac = {64'd0, a} - (128'd1 << p);
    frac = (frac << 52) >> p;
    return {1'b0, 11'(1023 + p), frac[51:0]};
  endfunction

  function automatic logic [63:0] ref_to_int(input logic [63:0] a);
    int e;
    logic [127:0] v;
    e = int'(a[62:52]);
    if (e == 2047) return ONES;
    if (a[63]) return 64'd0;
    if (e < 1023) return 64'd0;
    if (e - 1023 >= 64) return ONES;
    v = ({75'd0, 1'b1, a[51:0]} << (e - 1023)) >> 52;
    return v[63:0];
  endfunction

  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
    int ea, eb, e;
    logic s;
    logic [127:0] p;
    ea = int'(a[62:52]);
    eb = int'(b[62:52]);
    s  = a[63] ^ b[63];
    if (ea == 2047 || eb == 2047) return QNAN;
    if (ea == 0 || eb == 0) return {s, 63'd0};
    p = {75'd0, 1'b1, a[51:0]} * {75'd0, 1'b1, b[51:0]};
    e = ea + eb - 1023;
    if (p >= (128'd1 << 105)) begin
      p = p >> 1;
      e++;
    end
    return pack_dbl(s, e, p[103:52]);
  endfunction

  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b);
    int ea, eb, e;
    logic s;
    logic [127:0] q;
    ea = int'(a[62:52]);
    eb = int'(b[62:52]);
    s  = a[63] ^ b[63];
    if (ea == 2047 || eb == 2047) return QNAN;
    if (ea == 0 && eb == 0) return QNAN;
    if (eb == 0) return {s, 11'h7FF, 52'd0};
    if (ea == 0) return {s, 63'd0};
    q = ({75'd0, 1'b1, a[51:0]} << 53) / {75'd0, 1'b1, b[51:0]};
    e = ea - eb + 1023;
    if (q < (128'd1 << 53)) begin
      q = q << 1;
      e--;
    end
    return pack_dbl(s, e, q[52:1]);
  endfunction

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      3'd1: return ref_to_float(a);
      3'd2: return ref_to_int(a);
      3'd3: return ref_mul(a, b);
`ifdef FPU_DIVIDE_EN
      3'd4: return ref_div(a, b);
`endif
      default: return 64'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op);
    if (op == 3'd3) return 56;
`ifdef FPU_DIVIDE_EN
    if (op == 3'd4) return 57;
`endif
    return 2;
  endfunction

  function automatic logic [63:0] rand_dbl(input int lo, input int hi);
    logic [63:0] d;
    int r, e;
    r = int'($urandom_range(0, 19));
    if (r == 0) e = 0;
    else if (r == 1) e = 2047;
    else if (r < 5) e = int'($urandom_range(1, 2046));
    else e = int'($urandom_range(lo, hi));
    d = {$urandom, $urandom};
    d[62:52] = 11'(e);
    return d;
  endfunction

  // Issue one command in the cycle before the edge that samples it, then watch it to completion
  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_res);
    int lat, bad;
    logic [63:0] held;
    lat  = ref_lat(op);
    bad  = 0;
    held = RESULT;
    OP = op; A = a; B = b;
    @(posedge clk); #1;
    OP = 3'd0;
    if (fpu_done) bad++;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (k < lat) begin
        if (fpu_done || !busy || (RESULT !== held)) bad++;
      end
    end
    check_eq({tag, " in-flight"}, 64'(bad), 64'd0);
    check_eq({tag, " done"}, 64'(fpu_done), 64'd1);
    check_eq({tag, " busy"}, 64'(busy), 64'd0);
    check_eq({tag, " result"}, RESULT, exp_res);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [63:0] ra, rb;
    int cnt;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1; OP = 3'd0; A = 64'd0; B = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset RESULT", RESULT, 64'd0);
    check_eq("reset done", 64'(fpu_done), 64'd0);
    check_eq("reset busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("tofloat 2^28", 3'd1, 64'h1000_0000, 64'd0, 64'h41B0_0000_0000_0000);
    run_op("tofloat 156.25M", 3'd1, 64'd156250000, 64'd0, 64'h41A2_A05F_2000_0000);
    run_op("tofloat zero", 3'd1, 64'd0, 64'd0, 64'd0);
    run_op("mul 3x0.5", 3'd3, 64'h4008_0000_0000_0000, 64'h3FE0_0000_0000_0000, 64'h3FF8_0000_0000_0000);
    run_op("mul overflow", 3'd3, 64'h7FE0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h7FF0_0000_0000_0000);
    run_op("illegal 5", 3'd5, 64'h1234, 64'h5678, 64'd0);
    run_op("toint 2^28", 3'd2, 64'h41B0_0000_0000_0000, 64'd0, 64'h1000_0000);
    run_op("toint -1.5", 3'd2, 64'hBFF8_0000_0000_0000, 64'd0, 64'd0);
    run_op("toint 2^64", 3'd2, 64'h43F0_0000_0000_0000, 64'd0, ONES);
    run_op("illegal 7", 3'd7, 64'h1, 64'h1, 64'd0);
`ifdef FPU_DIVIDE_EN
    run_op("div 1/3", 3'd4, 64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 64'h3FD5_5555_5555_5555);
    run_op("div by zero", 3'd4, 64'h3FF0_0000_0000_0000, 64'd0, 64'h7FF0_0000_0000_0000);
    run_op("div 0/0", 3'd4, 64'd0, 64'd0, QNAN);
`else
    run_op("tofloat 3", 3'd1, 64'd3, 64'd0, 64'h4008_0000_0000_0000);
    run_op("div disabled", 3'd4, 64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 64'd0);
`endif

    // Busy handling: stray strobe at cycle 10 ignored, new command at the completion edge accepted
    cnt = 0;
    OP = 3'd3; A = 64'h4008_0000_0000_0000; B = 64'h3FE0_0000_0000_0000;
    @(posedge clk); #1;
    OP = 3'd0;
    for (int k = 1; k <= 56; k++) begin
      if (k == 10) begin OP = 3'd1; A = 64'd5; end
      if (k == 56) begin OP = 3'd1; A = 64'h1000_0000; end
      @(posedge clk); #1;
      OP = 3'd0;
      if (k < 56 && fpu_done) cnt++;
    end
    check_eq("b2b early done", 64'(cnt), 64'd0);
    check_eq("b2b done 56", 64'(fpu_done), 64'd1);
    check_eq("b2b result 56", RESULT, 64'h3FF8_0000_0000_0000);
    check_eq("b2b busy 56", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check_eq("b2b done 57", 64'(fpu_done), 64'd0);
    @(posedge clk); #1;
    check_eq("b2b done 58", 64'(fpu_done), 64'd1);
    check_eq("b2b result 58", RESULT, 64'h41B0_0000_0000_0000);
    check_eq("b2b busy 58", 64'(busy), 64'd0);

    // Asynchronous reset during a long operation
`ifdef FPU_DIVIDE_EN
    OP = 3'd4;
`else
    OP = 3'd3;
`endif
    A = 64'h3FF0_0000_0000_0000; B = 64'h4008_0000_0000_0000;
    @(posedge clk); #1;
    OP = 3'd0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("abort RESULT", RESULT, 64'd0);
    check_eq("abort busy", 64'(busy), 64'd0);
    check_eq("abort done", 64'(fpu_done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (fpu_done || busy) cnt++;
    end
    check_eq("abort no done", 64'(cnt), 64'd0);
    run_op("after abort", 3'd1, 64'd1000, 64'd0, ref_to_float(64'd1000));

    // Randomized commands against the reference model
    for (int i = 0; i < 120; i++) begin
      rop = 3'($urandom_range(1, 7));
      if (rop > 3'd4 && $urandom_range(0, 2) != 0) rop = 3'($urandom_range(1, 4));
      case (rop)
        3'd1: begin ra = {$urandom, $urandom} >> $urandom_range(0, 63); rb = 64'd0; end
        3'd2: begin ra = rand_dbl(1000, 1090); rb = 64'd0; end
        default: begin ra = rand_dbl(900, 1150); rb = rand_dbl(900, 1150); end
      endcase
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, ref_result(rop, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
